// File: rtl/tnet_dbg_snap_pkg.sv
// Shared types and constants for the TNET debug snapshot block.
// Word indices and field positions used by the read-side word mux.
package tnet_dbg_snap_pkg;

  typedef enum logic {
    DBG_LIVE   = 1'b0,
    DBG_FROZEN = 1'b1
  } TYPE_TNET_DBG_ST;

  localparam logic [2:0] DBG_W_STAT   = 3'd0;
  localparam logic [2:0] DBG_W_HIST0  = 3'd1;
  localparam logic [2:0] DBG_W_HIST1  = 3'd2;
  localparam logic [2:0] DBG_W_HIST2  = 3'd3;
  localparam logic [2:0] DBG_W_HIST3  = 3'd4;
  localparam logic [2:0] DBG_W_EHIST  = 3'd5;
  localparam logic [2:0] DBG_W_TSTAMP = 3'd6;
  localparam logic [2:0] DBG_W_CTRL   = 3'd7;

  localparam int DBG_F0_ERR_ID_LSB  = 24;
  localparam int DBG_F0_CMD_ST_LSB  = 16;
  localparam int DBG_F0_RDY_LSB     = 8;
  localparam int DBG_F0_ERRCNT_LSB  = 0;
  localparam int DBG_F7_FROZEN_BIT  = 31;
  localparam int DBG_F7_ARM_BIT     = 30;
  localparam int DBG_F7_FCNT_LSB    = 0;

  // History is served as four 32-bit words regardless of HIST_W.
  localparam int DBG_HIST_EXT_W = 128;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tnet_dbg_snap_if.sv
// Processor-side read port of the debug snapshot: request/address in,
// one-cycle-latency data/valid out.
interface tnet_dbg_snap_if;
  logic        rd_req_i;
  logic [2:0]  rd_addr_i;
  logic [31:0] rd_dt_o;
  logic        rd_vld_o;

  modport master (output rd_req_i, rd_addr_i, input  rd_dt_o, rd_vld_o);
  modport slave  (input  rd_req_i, rd_addr_i, output rd_dt_o, rd_vld_o);
endinterface

// File: rtl/tnet_dbg_word_mux.sv
// Combinational 8:1 selection of 32-bit debug words with field packing.
module tnet_dbg_word_mux
  import tnet_dbg_snap_pkg::*;
#(
  parameter int HIST_W  = 100,
  parameter int EHIST_W = 32
) (
  input  logic [2:0]         i_addr,
  input  logic [4:0]         i_cmd_st,
  input  logic [HIST_W-1:0]  i_hist,
  input  logic [7:0]         i_ready_cnt,
  input  logic [7:0]         i_error_cnt,
  input  logic [3:0]         i_error_id,
  input  logic [EHIST_W-1:0] i_error_hist,
  input  logic [31:0]        i_tstamp,
  input  logic               i_frozen,
  input  logic               i_arm,
  input  logic [7:0]         i_freeze_cnt,
  output logic [31:0]        o_word
);

  logic [DBG_HIST_EXT_W-1:0] w_hist_ext;
  assign w_hist_ext = DBG_HIST_EXT_W'(i_hist);

  always_comb begin
    // NOTE: default first so every path assigns o_word and no latch is inferred.
    o_word = '0;
    case (i_addr)
      DBG_W_STAT: begin
        o_word[DBG_F0_ERR_ID_LSB +: 4] = i_error_id;
        o_word[DBG_F0_CMD_ST_LSB +: 5] = i_cmd_st;
        o_word[DBG_F0_RDY_LSB    +: 8] = i_ready_cnt;
        o_word[DBG_F0_ERRCNT_LSB +: 8] = i_error_cnt;
      end
      DBG_W_HIST0:  o_word = w_hist_ext[31:0];
      DBG_W_HIST1:  o_word = w_hist_ext[63:32];
      DBG_W_HIST2:  o_word = w_hist_ext[95:64];
      DBG_W_HIST3:  o_word = w_hist_ext[127:96];
      DBG_W_EHIST:  o_word = 32'(i_error_hist);
      DBG_W_TSTAMP: o_word = i_tstamp;
      DBG_W_CTRL: begin
        o_word[DBG_F7_FROZEN_BIT]    = i_frozen;
        o_word[DBG_F7_ARM_BIT]       = i_arm;
        o_word[DBG_F7_FCNT_LSB +: 8] = i_freeze_cnt;
      end
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/tnet_dbg_snap.sv
// Live/frozen snapshot of the TNET command-watch debug outputs, read as
// eight 32-bit words. Optional freeze timestamp: TNET_DBG_TSTAMP_EN.
module tnet_dbg_snap
  import tnet_dbg_snap_pkg::*;
#(
  parameter int HIST_W  = 100,
  parameter int EHIST_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [4:0]         cmd_st_di,
  input  logic [HIST_W-1:0]  cmd_hist_di,
  input  logic [7:0]         ready_cnt_di,
  input  logic [7:0]         error_cnt_di,
  input  logic [3:0]         error_id_di,
  input  logic [EHIST_W-1:0] error_hist_di,
  input  logic               snap_req_i,
  input  logic               release_i,
  input  logic               arm_i,
  tnet_dbg_snap_if.slave     rd_if,
  output logic               frozen_o,
  output logic [7:0]         freeze_cnt_o
);

  TYPE_TNET_DBG_ST    r_state;
  logic               r_frozen;
  logic [7:0]         r_freeze_cnt;
  logic [7:0]         r_err_prev;
  logic [4:0]         r_cmd_st;
  logic [HIST_W-1:0]  r_hist;
  logic [7:0]         r_ready_cnt;
  logic [7:0]         r_error_cnt;
  logic [3:0]         r_error_id;
  logic [EHIST_W-1:0] r_error_hist;
  logic [31:0]        r_rd_dt;
  logic               r_rd_vld;
  logic [31:0]        w_word;
  logic [31:0]        w_tstamp;
  logic               w_err_new;
  logic               w_trigger;

  assign w_err_new = (error_cnt_di != r_err_prev);
  assign w_trigger = (r_state == DBG_LIVE) && (snap_req_i || (arm_i && w_err_new));

  // Snap beats release in LIVE; release beats snap in FROZEN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (!rst_ni) begin
      r_state      <= DBG_LIVE;
      r_frozen     <= 1'b0;
      r_freeze_cnt <= 8'd0;
    end else begin
      case (r_state)
        DBG_LIVE: if (w_trigger) begin
          r_state      <= DBG_FROZEN;
          r_frozen     <= 1'b1;
          r_freeze_cnt <= sat_inc8(r_freeze_cnt);
        end
        DBG_FROZEN: if (release_i) begin
          r_state  <= DBG_LIVE;
          r_frozen <= 1'b0;
        end
        default: begin
          r_state  <= DBG_LIVE;
          r_frozen <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err_prev <= 8'd0;
    else         r_err_prev <= error_cnt_di;
  end

  // The trigger cycle is still LIVE, so the captured image includes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: snapshot is a handful of flops, not a RAM, so it is reset to a known image.
    if (!rst_ni) begin
      r_cmd_st     <= '0;
      r_hist       <= '0;
      r_ready_cnt  <= '0;
      r_error_cnt  <= '0;
      r_error_id   <= '0;
      r_error_hist <= '0;
    end else if (r_state == DBG_LIVE) begin
      r_cmd_st     <= cmd_st_di;
      r_hist       <= cmd_hist_di;
      r_ready_cnt  <= ready_cnt_di;
      r_error_cnt  <= error_cnt_di;
      r_error_id   <= error_id_di;
      r_error_hist <= error_hist_di;
    end
  end

`ifdef TNET_DBG_TSTAMP_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_tstamp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cyc_cnt <= 32'd0;
      r_tstamp  <= 32'd0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_trigger) r_tstamp <= r_cyc_cnt;
    end
  end

  assign w_tstamp = r_tstamp;
`else
  assign w_tstamp = 32'd0;
`endif

  tnet_dbg_word_mux #(
    .HIST_W  (HIST_W),
    .EHIST_W (EHIST_W)
  ) u_word_mux (
    .i_addr       (rd_if.rd_addr_i),
    .i_cmd_st     (r_cmd_st),
    .i_hist       (r_hist),
    .i_ready_cnt  (r_ready_cnt),
    .i_error_cnt  (r_error_cnt),
    .i_error_id   (r_error_id),
    .i_error_hist (r_error_hist),
    .i_tstamp     (w_tstamp),
    .i_frozen     (r_frozen),
    .i_arm        (arm_i),
    .i_freeze_cnt (r_freeze_cnt),
    .o_word       (w_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_dt  <= 32'd0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= rd_if.rd_req_i;
      if (rd_if.rd_req_i) r_rd_dt <= w_word;
    end
  end

  assign rd_if.rd_dt_o  = r_rd_dt;
  assign rd_if.rd_vld_o = r_rd_vld;
  assign frozen_o       = r_frozen;
  assign freeze_cnt_o   = r_freeze_cnt;

endmodule

// File: tb/tb_tnet_dbg_snap.sv
// Self-checking bench for tnet_dbg_snap: directed steps plus a randomized
// phase, all checked each cycle against a behavioural model.
module tb_tnet_dbg_snap;
  localparam int HIST_W  = 100;
  localparam int EHIST_W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [4:0]         cmd_st;
  logic [HIST_W-1:0]  cmd_hist;
  logic [7:0]         ready_cnt;
  logic [7:0]         error_cnt;
  logic [3:0]         error_id;
  logic [EHIST_W-1:0] error_hist;
  logic               snap_req;
  logic               rel;
  logic               arm;
  logic               frozen;
  logic [7:0]         freeze_cnt;

  tnet_dbg_snap_if rd_if();

  always #5 clk = ~clk;

  tnet_dbg_snap #(.HIST_W(HIST_W), .EHIST_W(EHIST_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_st_di     (cmd_st),
    .cmd_hist_di   (cmd_hist),
    .ready_cnt_di  (ready_cnt),
    .error_cnt_di  (error_cnt),
    .error_id_di   (error_id),
    .error_hist_di (error_hist),
    .snap_req_i    (snap_req),
    .release_i     (rel),
    .arm_i         (arm),
    .rd_if         (rd_if),
    .frozen_o      (frozen),
    .freeze_cnt_o  (freeze_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: what the snapshot should hold and what software sees.
  bit                 m_frozen;
  logic [4:0]         m_st;
  logic [HIST_W-1:0]  m_hist;
  logic [7:0]         m_rdy, m_ecnt, m_prev, m_fcnt;
  logic [3:0]         m_eid;
  logic [EHIST_W-1:0] m_ehist;
  logic [31:0]        m_cyc, m_ts, m_dt;
  bit                 m_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_frozen = 0; m_st = '0; m_hist = '0; m_rdy = '0; m_ecnt = '0; m_prev = '0;
    m_fcnt = '0; m_eid = '0; m_ehist = '0; m_cyc = '0; m_ts = '0; m_dt = '0; m_vld = 0;
  endfunction

  function automatic logic [31:0] model_word(input logic [2:0] a, input logic arm_now);
    logic [127:0] h = 128'(m_hist);
    case (a)
      3'd0:    return {4'h0, m_eid, 3'b000, m_st, m_rdy, m_ecnt};
      3'd5:    return 32'(m_ehist);
`ifdef TNET_DBG_TSTAMP_EN
      3'd6:    return m_ts;
`else
      3'd6:    return 32'd0;
`endif
      3'd7:    return {m_frozen, arm_now, 22'd0, m_fcnt};
      default: return h[32*(int'(a)-1) +: 32];
    endcase
  endfunction

  function automatic void model_step();
    bit trig;
    if (rd_if.rd_req_i) m_dt = model_word(rd_if.rd_addr_i, arm);
    m_vld = rd_if.rd_req_i;
    trig = !m_frozen && (snap_req || (arm && error_cnt != m_prev));
    if (!m_frozen) begin
      m_st = cmd_st; m_hist = cmd_hist; m_rdy = ready_cnt;
      m_ecnt = error_cnt; m_eid = error_id; m_ehist = error_hist;
    end
    if (m_frozen) begin
      if (rel) m_frozen = 0;
    end else if (trig) begin
      m_frozen = 1;
      if (m_fcnt != 8'hFF) m_fcnt = m_fcnt + 8'd1;
      m_ts = m_cyc;
    end
    m_prev = error_cnt;
    m_cyc  = m_cyc + 32'd1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("rd_vld", 32'(rd_if.rd_vld_o), 32'(m_vld));
    check("rd_dt", rd_if.rd_dt_o, m_dt);
    check("frozen", 32'(frozen), 32'(m_frozen));
    check("freeze_cnt", 32'(freeze_cnt), 32'(m_fcnt));
  endtask

  task automatic do_read(input logic [2:0] a);
    rd_if.rd_req_i  = 1'b1;
    rd_if.rd_addr_i = a;
    cycle();
    rd_if.rd_req_i  = 1'b0;
    check("rd_vld_after_req", 32'(rd_if.rd_vld_o), 32'd1);
  endtask

  logic [HIST_W-1:0] h0, h1;
  logic [127:0]      rnd;

  initial begin
    rst_n = 1'b0;
    cmd_st = '0; cmd_hist = '0; ready_cnt = '0; error_cnt = '0; error_id = '0;
    error_hist = '0; snap_req = 1'b0; rel = 1'b0; arm = 1'b0;
    rd_if.rd_req_i = 1'b0; rd_if.rd_addr_i = '0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;

    // Reset image: every word reads zero.
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a));
      check($sformatf("reset_word%0d", a), rd_if.rd_dt_o, 32'd0);
    end

    // Live tracking of state and error count.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    h0 = rnd[HIST_W-1:0];
    cmd_st = 5'd9; error_cnt = 8'd3; cmd_hist = h0;
    cycle();
    cycle();
    do_read(3'd0);
    check("live_word0", rd_if.rd_dt_o, 32'h0009_0003);

    // Armed freeze on a new error; history change afterwards is not captured.
    arm = 1'b1; error_cnt = 8'd4; error_id = 4'hA;
    cycle();
    check("armed_frozen", 32'(frozen), 32'd1);
    check("armed_fcnt", 32'(freeze_cnt), 32'd1);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    h1 = ~rnd[HIST_W-1:0];
    cmd_hist = h1;
    cycle();
    do_read(3'd0);
    check("frozen_word0", rd_if.rd_dt_o, 32'h0A09_0004);
    do_read(3'd1);
    check("frozen_word1", rd_if.rd_dt_o, h0[31:0]);

    // Snap and release together while frozen: release wins.
    snap_req = 1'b1; rel = 1'b1;
    cycle();
    snap_req = 1'b0; rel = 1'b0;
    check("sim_rel_frozen", 32'(frozen), 32'd0);
    check("sim_rel_fcnt", 32'(freeze_cnt), 32'd1);
    do_read(3'd7);
    check("sim_rel_w7_bit31", 32'(rd_if.rd_dt_o[31]), 32'd0);

    // Unarmed error change does not freeze; then saturate the freeze counter.
    arm = 1'b0; error_cnt = 8'd5;
    cycle();
    cycle();
    check("unarmed_no_freeze", 32'(frozen), 32'd0);
    for (int i = 0; i < 255; i++) begin
      snap_req = 1'b1;
      cycle();
      snap_req = 1'b0; rel = 1'b1;
      cycle();
      rel = 1'b0;
    end
    check("fcnt_saturated", 32'(freeze_cnt), 32'hFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cmd_st     = 5'($urandom);
      cmd_hist   = rnd[HIST_W-1:0];
      ready_cnt  = 8'($urandom);
      error_id   = 4'($urandom);
      error_hist = EHIST_W'($urandom);
      if ($urandom_range(0, 7) == 0) error_cnt = error_cnt + 8'd1;
      arm        = 1'($urandom);
      snap_req   = ($urandom_range(0, 15) == 0);
      rel        = ($urandom_range(0, 3) == 0);
      rd_if.rd_req_i  = 1'($urandom);
      rd_if.rd_addr_i = 3'($urandom);
      cycle();
    end
    snap_req = 1'b0; rel = 1'b0; arm = 1'b0;

    // Reset in the middle of a read: valid drops immediately.
    rd_if.rd_req_i = 1'b1; rd_if.rd_addr_i = 3'd0;
    cycle();
    rd_if.rd_req_i = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midread_rst_vld", 32'(rd_if.rd_vld_o), 32'd0);
    check("midread_rst_dt", rd_if.rd_dt_o, 32'd0);
    cycle();
    rst_n = 1'b1;

    // Snap in cycle 100 after reset release, then read the timestamp word.
    repeat (100) cycle();
    snap_req = 1'b1;
    cycle();
    snap_req = 1'b0;
    do_read(3'd6);
`ifdef TNET_DBG_TSTAMP_EN
    check("tstamp_word6", rd_if.rd_dt_o, 32'd100);
`else
    check("tstamp_word6", rd_if.rd_dt_o, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tnet_dbg_snap.md
Name: tnet_dbg_snap

Overview:
- Downstream consumer of the TNET command-watch debug outputs: current state code, 100-bit state history, ready count, error count/ID, 32-bit error history.
- Holds a live-tracking or frozen snapshot of those outputs.
- Serves the snapshot to the processor-side register interface as eight 32-bit words through a one-cycle-latency read port.
- Freezes on software request, or automatically on a new command error when armed, so that the history is not overwritten before readout.

Parameters:
- HIST_W, 100, width of the state history input; must be ≤128.
- EHIST_W, 32, width of the error history input; must be ≤32.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_st_di  in  5  current command state code
- cmd_hist_di  in  HIST_W  state history, 5 bits per entry, newest in LSBs
- ready_cnt_di  in  8  NOT_READY entry count
- error_cnt_di  in  8  error count
- error_id_di  in  4  last error ID
- error_hist_di  in  EHIST_W  error ID history
- snap_req_i  in  1  pulse: freeze now
- release_i  in  1  pulse: return to live tracking
- arm_i  in  1  level: freeze on new error
- rd_req_i  in  1  read strobe
- rd_addr_i  in  3  word index
- rd_dt_o  out  32  read data
- rd_vld_o  out  1  read data valid
- frozen_o  out  1  1 while in FROZEN
- freeze_cnt_o  out  8  freeze events, saturating

Behaviour:
- Reset (async assert, sync release):
  - FSM in LIVE.
  - All snapshot registers, rd_dt_o, rd_vld_o, frozen_o and freeze_cnt_o are 0.
  - err_prev is 0.
- FSM states: LIVE, FROZEN.
- err_new = (error_cnt_di != err_prev). err_prev is registered every cycle in both states.
- LIVE:
  - Snapshot registers load all inputs every cycle, so they lag the inputs by 1 cycle.
  - Go to FROZEN when snap_req_i is high, or when arm_i and err_new are both high.
  - The transition cycle still loads, so the captured values are the inputs sampled in the trigger cycle. This includes the new error_cnt/ID.
- FROZEN:
  - Snapshot registers hold.
  - release_i returns the FSM to LIVE; loading resumes on the next cycle.
  - snap_req_i and err_new are ignored.
- Simultaneous snap_req_i and release_i in LIVE: snap wins, go to FROZEN.
- Simultaneous snap_req_i and release_i in FROZEN: release wins, go to LIVE.
- freeze_cnt_o increments on each LIVE→FROZEN transition and saturates at 255.
- frozen_o is registered and equals (state==FROZEN).
- Read port:
  - Each rd_req_i is accepted unconditionally; no backpressure.
  - rd_vld_o is high exactly one cycle after rd_req_i.
  - rd_dt_o is updated only on accepted reads and holds otherwise.
  - Back-to-back requests give back-to-back data.
  - A read in the same cycle as a freeze returns the pre-freeze snapshot register contents.
- Word map (unused bits zero):
  - 0: {error_id[27:24], cmd_st[20:16], ready_cnt[15:8], error_cnt[7:0]}
  - 1: hist[31:0]
  - 2: hist[63:32]
  - 3: hist[95:64]
  - 4: hist[HIST_W-1:96], zero-extended
  - 5: error_hist, zero-extended
  - 6: timestamp (see optional feature)
  - 7: {frozen[31], arm_i[30], freeze_cnt[7:0]}. Live values, not snapshot.
- Reset mid-read: rd_vld_o is forced to 0 immediately; the pending read is dropped.

Optional Feature:
- Macro: TNET_DBG_TSTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter runs from reset; it is 0 in the first cycle after reset release and wraps at 2^32.
  - The counter value is captured into the timestamp register on every LIVE→FROZEN transition.
  - Word 6 returns the timestamp register.
- When undefined:
  - No counter or timestamp register is built.
  - Word 6 reads 0.

Decomposition:
- Shared package/defines file holds:
  - TYPE_TNET_DBG_ST enum {DBG_LIVE, DBG_FROZEN}.
  - Word-index constants DBG_W_STAT..DBG_W_CTRL (0..7).
  - Field bit positions for word 0 and word 7.
- One natural sub-module: tnet_dbg_word_mux, a combinational 8:1 32-bit word select with field packing. The FSM, snapshot registers and read register stay in the top module.

Test Plan:
- Reset, then read words 0–7 → all 0. rd_vld_o is high 1 cycle after each request.
- LIVE with cmd_st_di=5'd9 and error_cnt_di=8'd3 held 2 cycles, then read word 0 → 32'h0009_0003 (error_id 0).
- arm_i=1; error_cnt_di steps 3→4 with error_id_di=4'hA; then cmd_hist_di changes → frozen_o=1 next cycle, freeze_cnt_o=1, word 0 reads 32'h0A09_0004, word 1 keeps the pre-change history.
- In FROZEN: pulse snap_req_i and release_i together → LIVE; freeze_cnt_o stays 1; word 7 bit31=0.
- arm_i=0 and error_cnt_di changes → no freeze. Then snap_req_i 255 times with a release between each → freeze_cnt_o saturates at 8'hFF.
- With TNET_DBG_TSTAMP_EN: snap_req_i in cycle 100 after reset release → word 6 reads 32'd100. Without the macro, word 6 reads 0.
